// File: rtl/swerv_ifu_fetch_pkg.sv
// rtl/swerv_ifu_fetch_pkg.sv - shared fetch-unit types and AXI constants
// Purpose: fetch FSM state encoding, fixed AXI read attributes, PC helper.
// Ports: none (package swerv_types).
package swerv_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } fetch_state_e;

  localparam logic [2:0] AXI_ARSIZE_64  = 3'd3;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // PC[31:1] of the first halfword of the next aligned doubleword.
  function automatic logic [30:0] next_dw_pc(input logic [30:0] pc);
    return {pc[30:2] + 29'd1, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_axi_rd_if.sv
// rtl/ifu_axi_rd_if.sv - AXI read handshake, request tag and discard tracking
// Purpose: runs the IDLE/REQ/WAIT/DELIVER fetch sequence on the AXI AR/R channels.
// Ports: clk, rst_l; flush, fetch_en, bus_clk_en, fetch_addr (requests);
//        arvalid/arready/arid/araddr (AR); rvalid/rlast/rid/rready (R);
//        beat_take (keep this beat), st_idle, st_deliver (state flags).
import swerv_types::*;

module ifu_axi_rd_if (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        flush,
  input  logic        fetch_en,
  input  logic        bus_clk_en,
  input  logic [31:0] fetch_addr,
  output logic        arvalid,
  input  logic        arready,
  output logic [2:0]  arid,
  output logic [31:0] araddr,
  input  logic        rvalid,
  input  logic        rlast,
  input  logic [2:0]  rid,
  output logic        rready,
  output logic        beat_take,
  output logic        st_idle,
  output logic        st_deliver
);

  fetch_state_e state, state_n;
  logic [2:0]   tag;
  logic [2:0]   req_tag;
  logic [31:0]  req_addr;
  logic         discard, discard_n;
  logic         ar_hs;
  logic         load_addr;
  logic         beat;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= IDLE;
      tag      <= 3'd0;
      req_tag  <= 3'd0;
      req_addr <= 32'd0;
      discard  <= 1'b0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
      if (load_addr) req_addr <= fetch_addr;
      if (ar_hs) begin
        req_tag <= tag;
        tag     <= tag + 3'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    discard_n = discard;
    arvalid   = 1'b0;
    rready    = 1'b0;
    ar_hs     = 1'b0;
    load_addr = 1'b0;
    beat      = 1'b0;
    beat_take = 1'b0;
    case (state)
      IDLE: begin
        discard_n = 1'b0;
        // A flush in IDLE only retargets the PC; the request starts a cycle
        // later so the latched address is the redirected one.
        if (fetch_en && bus_clk_en && !flush) begin
          state_n   = REQ;
          load_addr = 1'b1;
        end
      end
      REQ: begin
        // Once raised, arvalid must stay up until accepted, even on flush.
        arvalid = 1'b1;
        if (flush) discard_n = 1'b1;
        if (arready && bus_clk_en) begin
          ar_hs   = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        rready = 1'b1;
        if (flush) discard_n = 1'b1;
        // Beats with a stale tag are accepted by rready and dropped here.
        beat = rvalid && rlast && (rid == req_tag) && bus_clk_en;
        if (beat) begin
          if (discard || flush) begin
            state_n = IDLE;
          end else begin
            state_n   = DELIVER;
            beat_take = 1'b1;
          end
        end
      end
      DELIVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign arid       = tag;
  assign araddr     = req_addr;
  assign st_idle    = (state == IDLE);
  assign st_deliver = (state == DELIVER);

endmodule

// File: rtl/swerv_ifu_fetch.sv
// rtl/swerv_ifu_fetch.sv - cacheless SweRV fetch unit: PC, flush redirect, decode hand-off
// Purpose: fetches one aligned doubleword per AXI read and presents up to two
//          32-bit instructions to decode. Optional feature macro: IFU_ICAF_EN
//          (error response reported as an access fault on slot 0).
// Ports: clk, rst_l; exu_flush_final/exu_flush_path_final (redirect);
//        dec_ib3_valid_d (backpressure); ifu_bus_clk_en; ifu_axi_ar* / ifu_axi_r*
//        (AXI read); ifu_i0_* / ifu_i1_* (decode slots); ifu_miss_state_idle.
import swerv_types::*;

module swerv_ifu_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        exu_flush_final,
  input  logic [30:0] exu_flush_path_final,
  input  logic        dec_ib3_valid_d,
  input  logic        ifu_bus_clk_en,
  output logic        ifu_axi_arvalid,
  input  logic        ifu_axi_arready,
  output logic [2:0]  ifu_axi_arid,
  output logic [31:0] ifu_axi_araddr,
  output logic [7:0]  ifu_axi_arlen,
  output logic [2:0]  ifu_axi_arsize,
  output logic [1:0]  ifu_axi_arburst,
  input  logic        ifu_axi_rvalid,
  input  logic        ifu_axi_rlast,
  input  logic [2:0]  ifu_axi_rid,
  input  logic [63:0] ifu_axi_rdata,
  input  logic [1:0]  ifu_axi_rresp,
  output logic        ifu_axi_rready,
  output logic        ifu_i0_valid,
  output logic        ifu_i1_valid,
  output logic [31:0] ifu_i0_instr,
  output logic [31:0] ifu_i1_instr,
  output logic [30:0] ifu_i0_pc,
  output logic [30:0] ifu_i1_pc,
  output logic        ifu_i0_pc4,
  output logic        ifu_i1_pc4,
  output logic        ifu_i0_icaf,
  output logic        ifu_miss_state_idle
);

  logic [30:0] pc;
  logic [63:0] rdata_q;
  logic        beat_take;
  logic        st_idle;
  logic        st_deliver;
  logic        deliver;
  logic        fault;

  ifu_axi_rd_if u_rd_if (
    .clk        (clk),
    .rst_l      (rst_l),
    .flush      (exu_flush_final),
    .fetch_en   (!dec_ib3_valid_d),
    .bus_clk_en (ifu_bus_clk_en),
    .fetch_addr ({pc[30:2], 3'b000}),
    .arvalid    (ifu_axi_arvalid),
    .arready    (ifu_axi_arready),
    .arid       (ifu_axi_arid),
    .araddr     (ifu_axi_araddr),
    .rvalid     (ifu_axi_rvalid),
    .rlast      (ifu_axi_rlast),
    .rid        (ifu_axi_rid),
    .rready     (ifu_axi_rready),
    .beat_take  (beat_take),
    .st_idle    (st_idle),
    .st_deliver (st_deliver)
  );

`ifdef IFU_ICAF_EN
  logic [1:0] rresp_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)         rresp_q <= 2'b00;
    else if (beat_take) rresp_q <= ifu_axi_rresp;
  end

  assign fault = (rresp_q != 2'b00);
`else
  logic rresp_unused;
  assign rresp_unused = ^ifu_axi_rresp;
  assign fault        = 1'b0;
`endif

  // Flush always wins over the doubleword advance at the end of DELIVER.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      pc      <= RESET_VEC[31:1];
      rdata_q <= 64'd0;
    end else begin
      if (exu_flush_final) pc <= exu_flush_path_final;
      else if (st_deliver) pc <= next_dw_pc(pc);
      if (beat_take) rdata_q <= ifu_axi_rdata;
    end
  end

  // A flush in the DELIVER cycle kills both slots.
  assign deliver = st_deliver && !exu_flush_final;

  always_comb begin
    ifu_i0_valid = 1'b0;
    ifu_i1_valid = 1'b0;
    ifu_i0_instr = 32'd0;
    ifu_i1_instr = 32'd0;
    ifu_i0_pc    = 31'd0;
    ifu_i1_pc    = 31'd0;
    ifu_i0_icaf  = 1'b0;
    if (deliver) begin
      ifu_i0_valid = 1'b1;
      ifu_i0_pc    = pc;
      if (fault) begin
        ifu_i0_icaf = 1'b1;
      end else if (pc[1]) begin
        // Entry at the upper word: only one instruction left in this doubleword.
        ifu_i0_instr = rdata_q[63:32];
      end else begin
        ifu_i0_instr = rdata_q[31:0];
        ifu_i1_valid = 1'b1;
        ifu_i1_instr = rdata_q[63:32];
        ifu_i1_pc    = pc + 31'd2;
      end
    end
  end

  assign ifu_axi_arlen       = 8'd0;
  assign ifu_axi_arsize      = AXI_ARSIZE_64;
  assign ifu_axi_arburst     = AXI_BURST_INCR;
  assign ifu_i0_pc4          = 1'b1;
  assign ifu_i1_pc4          = 1'b1;
  assign ifu_miss_state_idle = st_idle;

endmodule

// File: tb/tb_swerv_ifu_fetch.sv
// tb/tb_swerv_ifu_fetch.sv - directed vector bench for swerv_ifu_fetch
module tb_swerv_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        flush;
  logic [30:0] path;
  logic        ib3;
  logic        bus_en;
  logic        arvalid, arready;
  logic [2:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rlast;
  logic [2:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rready;
  logic        i0_valid, i1_valid;
  logic [31:0] i0_instr, i1_instr;
  logic [30:0] i0_pc, i1_pc;
  logic        i0_pc4, i1_pc4, i0_icaf, miss_idle;

  logic [1:0]  resp_cfg = 2'b00;
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  swerv_ifu_fetch dut (
    .clk                  (clk),
    .rst_l                (rst_l),
    .exu_flush_final      (flush),
    .exu_flush_path_final (path),
    .dec_ib3_valid_d      (ib3),
    .ifu_bus_clk_en       (bus_en),
    .ifu_axi_arvalid      (arvalid),
    .ifu_axi_arready      (arready),
    .ifu_axi_arid         (arid),
    .ifu_axi_araddr       (araddr),
    .ifu_axi_arlen        (arlen),
    .ifu_axi_arsize       (arsize),
    .ifu_axi_arburst      (arburst),
    .ifu_axi_rvalid       (rvalid),
    .ifu_axi_rlast        (rlast),
    .ifu_axi_rid          (rid),
    .ifu_axi_rdata        (rdata),
    .ifu_axi_rresp        (rresp),
    .ifu_axi_rready       (rready),
    .ifu_i0_valid         (i0_valid),
    .ifu_i1_valid         (i1_valid),
    .ifu_i0_instr         (i0_instr),
    .ifu_i1_instr         (i1_instr),
    .ifu_i0_pc            (i0_pc),
    .ifu_i1_pc            (i1_pc),
    .ifu_i0_pc4           (i0_pc4),
    .ifu_i1_pc4           (i1_pc4),
    .ifu_i0_icaf          (i0_icaf),
    .ifu_miss_state_idle  (miss_idle)
  );

  function automatic logic [63:0] mem_dw(input logic [31:0] a);
    case (a)
      32'h0:   return 64'hb8201073_b0201073;
      32'h8:   return 64'h30509073_ee0000b7;
      default: return {a ^ 32'hdeadbeef, a ^ 32'h12345678};
    endcase
  endfunction

  // Memory slave: returns the single beat one cycle after each AR handshake.
  initial begin
    logic        hs, racc;
    logic [31:0] a;
    logic [2:0]  t;
    a = 32'd0;
    t = 3'd0;
    forever begin
      @(negedge clk);
      #1;
      hs   = rst_l && arvalid && arready && bus_en;
      racc = rst_l && rvalid && rready && bus_en;
      if (hs) begin
        a = araddr;
        t = arid;
      end
      @(posedge clk);
      #1;
      if (!rst_l || racc) rvalid = 1'b0;
      if (rst_l && hs) begin
        rvalid = 1'b1;
        rlast  = 1'b1;
        rid    = t;
        rdata  = mem_dw(a);
        rresp  = resp_cfg;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Wait for a request; counts slot-0 pulses seen on the way.
  task automatic wait_ar(input string name, output int nvalid);
    bit ok;
    ok = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i0_valid) nvalid++;
      if (arvalid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_ar_seen"}, ok, 1'b1);
  endtask

  // Wait for a delivery and stop further fetching right away.
  task automatic wait_dv(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i0_valid) begin
        ok  = 1'b1;
        ib3 = 1'b1;
        break;
      end
    end
    chk({name, "_dv_seen"}, ok, 1'b1);
  endtask

  task automatic chk_dv(input string name, input logic [31:0] e0, input logic [30:0] e0pc,
                        input logic e1v, input logic [31:0] e1, input logic [30:0] e1pc);
    chk({name, "_i0_instr"}, i0_instr, e0);
    chk({name, "_i0_pc"}, i0_pc, e0pc);
    chk({name, "_i1_valid"}, i1_valid, e1v);
    chk({name, "_icaf"}, i0_icaf, 1'b0);
    if (e1v) begin
      chk({name, "_i1_instr"}, i1_instr, e1);
      chk({name, "_i1_pc"}, i1_pc, e1pc);
    end
  endtask

  typedef struct {
    logic        fl;
    logic [30:0] fpath;
    logic [31:0] addr;
    logic [2:0]  id;
    logic [31:0] e0;
    logic [30:0] e0pc;
    logic        e1v;
    logic [31:0] e1;
    logic [30:0] e1pc;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nv;
    vecs[0] = '{1'b0, 31'h0,  32'h00, 3'd0, 32'hb0201073, 31'h0,  1'b1, 32'hb8201073, 31'h2};
    vecs[1] = '{1'b0, 31'h0,  32'h08, 3'd1, 32'hee0000b7, 31'h4,  1'b1, 32'h30509073, 31'h6};
    vecs[2] = '{1'b1, 31'h2,  32'h00, 3'd2, 32'hb8201073, 31'h2,  1'b0, 32'h0,        31'h0};
    vecs[3] = '{1'b0, 31'h0,  32'h08, 3'd3, 32'hee0000b7, 31'h4,  1'b1, 32'h30509073, 31'h6};
    vecs[4] = '{1'b1, 31'h6,  32'h08, 3'd4, 32'h30509073, 31'h6,  1'b0, 32'h0,        31'h0};
    vecs[5] = '{1'b1, 31'h0,  32'h00, 3'd5, 32'hb0201073, 31'h0,  1'b1, 32'hb8201073, 31'h2};
    vecs[6] = '{1'b1, 31'h10, 32'h20, 3'd6, 32'h12345658, 31'h10, 1'b1, 32'hdeadbecf, 31'h12};

    rst_l = 1'b0; flush = 1'b0; path = 31'd0; ib3 = 1'b1; bus_en = 1'b1;
    arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rid = 3'd0; rdata = 64'd0; rresp = 2'b00;

    repeat (3) @(negedge clk);
    chk("rst_idle", miss_idle, 1'b1);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_valids", {i0_valid, i1_valid, i0_icaf}, 3'b000);
    chk("rst_pc4", {i0_pc4, i1_pc4}, 2'b11);
    chk("rst_ar", {araddr, arid}, 35'd0);
    chk("rst_slots", {i0_instr, i0_pc}, 63'd0);
    chk("ar_const", {arlen, arsize, arburst}, {8'd0, 3'd3, 2'b01});
    rst_l = 1'b1;

    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      if (vecs[v].fl) begin
        flush = 1'b1;
        path  = vecs[v].fpath;
        @(negedge clk);
        flush = 1'b0;
      end
      ib3 = 1'b0;
      wait_ar($sformatf("v%0d", v), nv);
      chk($sformatf("v%0d_araddr", v), araddr, vecs[v].addr);
      chk($sformatf("v%0d_arid", v), arid, vecs[v].id);
      wait_dv($sformatf("v%0d", v));
      chk_dv($sformatf("v%0d", v), vecs[v].e0, vecs[v].e0pc, vecs[v].e1v, vecs[v].e1, vecs[v].e1pc);
    end

    // Flush while the beat is in flight: beat dropped, refetch at the target.
    @(negedge clk);
    ib3 = 1'b0;
    wait_ar("wf", nv);
    chk("wf_araddr0", {araddr, arid}, {32'h28, 3'd7});
    @(negedge clk);
    chk("wf_in_wait", {rready, rvalid}, 2'b11);
    flush = 1'b1;
    path  = 31'h8;
    @(negedge clk);
    flush = 1'b0;
    chk("wf_no_pulse0", i0_valid, 1'b0);
    wait_ar("wf2", nv);
    chk("wf_no_pulse", nv, 0);
    chk("wf_araddr1", {araddr, arid}, {32'h10, 3'd0});
    wait_dv("wf");
    chk_dv("wf", 32'h12345668, 31'h8, 1'b1, 32'hdeadbeff, 31'ha);

    // AR stall with a flush during it.
    @(negedge clk);
    arready = 1'b0;
    ib3     = 1'b0;
    wait_ar("st", nv);
    chk("st_ar0", {araddr, arid}, {32'h18, 3'd1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("st_hold%0d", i), {arvalid, araddr, arid}, {1'b1, 32'h18, 3'd1});
      flush = (i == 1);
      path  = 31'h4;
    end
    flush   = 1'b0;
    arready = 1'b1;
    nv = 0;
    for (int i = 0; i < 10 && arvalid; i++) begin
      @(negedge clk);
      if (i0_valid) nv++;
    end
    chk("st_ar_dropped", arvalid, 1'b0);
    begin
      int nv2;
      wait_ar("st2", nv2);
      chk("st_no_pulse", nv + nv2, 0);
    end
    chk("st_ar1", {araddr, arid}, {32'h08, 3'd2});
    wait_dv("st");
    chk_dv("st", 32'hee0000b7, 31'h4, 1'b1, 32'h30509073, 31'h6);

    // Decode backpressure holds off requests; release issues one next cycle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), arvalid, 1'b0);
    end
    ib3 = 1'b0;
    @(negedge clk);
    chk("bp_release", {arvalid, araddr, arid}, {1'b1, 32'h10, 3'd3});
    wait_dv("bp");
    chk_dv("bp", 32'h12345668, 31'h8, 1'b1, 32'hdeadbeff, 31'ha);

`ifdef IFU_ICAF_EN
    @(negedge clk);
    resp_cfg = 2'b10;
    ib3      = 1'b0;
    wait_ar("af", nv);
    chk("af_araddr", araddr, 32'h18);
    wait_dv("af");
    chk("af_icaf", {i0_icaf, i0_valid, i1_valid}, 3'b110);
    chk("af_instr", i0_instr, 32'd0);
    resp_cfg = 2'b00;
`endif

    // Asynchronous reset in the middle of a transaction.
    @(negedge clk);
    ib3 = 1'b0;
    wait_ar("ar", nv);
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    chk("async_rst", {miss_idle, rready, arvalid, i0_valid}, 4'b1000);
    ib3 = 1'b1;
    @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    ib3 = 1'b0;
    wait_ar("rr", nv);
    chk("rr_ar", {araddr, arid}, {32'h0, 3'd0});
    wait_dv("rr");
    chk_dv("rr", 32'hb0201073, 31'h0, 1'b1, 32'hb8201073, 31'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
